// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared types for the framebuffer loader
package matrix_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2
  } fb_state_e;

  // Full received bytes; the loader keeps the top BITDEPTH bits of each lane.
  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } pixel_t;

endpackage

// File: rtl/fb_timeout.sv
// rtl/fb_timeout.sv - loadable down-counter flagging an inter-byte timeout
module fb_timeout #(
  parameter int TIMEOUT = 100000,
  localparam int CW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= LOAD;
    end else if (enable && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/fb_loader.sv
// rtl/fb_loader.sv - frames the UART byte stream into RGB pixels for the HUB75 pixel RAMs
// Optional double buffering: define FB_LOADER_DBUF_EN.
module fb_loader
  import matrix_pkg::*;
#(
  parameter int  LENGTH   = 5,
  parameter int  SCAN_BIT = 3,
  parameter int  BITDEPTH = 8,
  parameter int  TIMEOUT  = 100000,
  localparam int ADDRMAX  = LENGTH * (1 << SCAN_BIT) - 1,
  localparam int AW       = $clog2(ADDRMAX + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
`ifdef FB_LOADER_DBUF_EN
  output logic [AW:0]           wr_addr,
`else
  output logic [AW-1:0]         wr_addr,
`endif
  output logic [3*BITDEPTH-1:0] wr_data,
  output logic                  wr_en1,
  output logic                  wr_en2,
  output logic                  frame_done,
  output logic                  frame_error
`ifdef FB_LOADER_DBUF_EN
  ,
  output logic                  disp_bank
`endif
);

  localparam logic [AW-1:0] ADDR_LAST = AW'(ADDRMAX);

  fb_state_e     state, state_next;
  logic [1:0]    byte_idx;
  logic [AW-1:0] addr;
  logic          half;
  pixel_t        pixel;
  logic          accept;
  logic          tmo_clear, tmo_enable, tmo_expired;
  logic          done_set, err_set;

  assign accept = rx_valid && rx_ready;

  fb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    rx_ready   = 1'b0;
    wr_en1     = 1'b0;
    wr_en2     = 1'b0;
    tmo_clear  = 1'b1;
    tmo_enable = 1'b0;
    done_set   = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        rx_ready = 1'b1;
        if (accept && (rx_data == SYNC_BYTE)) state_next = RECV;
      end
      RECV: begin
        rx_ready   = 1'b1;
        tmo_clear  = accept;
        tmo_enable = !accept;
        if (accept && (byte_idx == 2'd2)) begin
          state_next = WRITE;
        end else if (!accept && tmo_expired) begin
          state_next = IDLE;
          err_set    = 1'b1;
        end
      end
      WRITE: begin
        wr_en1 = !half;
        wr_en2 = half;
        if (half && (addr == ADDR_LAST)) begin
          state_next = IDLE;
          done_set   = 1'b1;
        end else begin
          state_next = RECV;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx    <= 2'd0;
      addr        <= '0;
      half        <= 1'b0;
      pixel       <= '0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_done  <= done_set;
      frame_error <= err_set;
      case (state)
        IDLE: begin
          if (accept && (rx_data == SYNC_BYTE)) begin
            byte_idx <= 2'd0;
            addr     <= '0;
            half     <= 1'b0;
          end
        end
        RECV: begin
          if (accept) begin
            case (byte_idx)
              2'd0:    begin pixel.r <= rx_data; byte_idx <= 2'd1; end
              2'd1:    begin pixel.g <= rx_data; byte_idx <= 2'd2; end
              default: begin pixel.b <= rx_data; byte_idx <= 2'd0; end
            endcase
          end
        end
        WRITE: begin
          if (addr == ADDR_LAST) begin
            addr <= '0;
            half <= 1'b1;
          end else begin
            addr <= addr + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign wr_data = {pixel.b[7 -: BITDEPTH], pixel.g[7 -: BITDEPTH], pixel.r[7 -: BITDEPTH]};

`ifdef FB_LOADER_DBUF_EN
  // The bank being filled is always the one the scanner is not showing.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_bank <= 1'b0;
    end else if (done_set) begin
      disp_bank <= !disp_bank;
    end
  end

  assign wr_addr = {!disp_bank, addr};
`else
  assign wr_addr = addr;
`endif

endmodule

// File: tb/tb_fb_loader.sv
// tb/tb_fb_loader.sv - self-checking bench for fb_loader (LENGTH=5, SCAN_BIT=1, TIMEOUT=64)
module tb_fb_loader;

  localparam int TMO   = 64;
  localparam int NHALF = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
`ifdef FB_LOADER_DBUF_EN
  logic [4:0]  wr_addr;
  logic        disp_bank;
`else
  logic [3:0]  wr_addr;
`endif
  logic [23:0] wr_data;
  logic        wr_en1, wr_en2, frame_done, frame_error;

  fb_loader #(.LENGTH(5), .SCAN_BIT(1), .BITDEPTH(8), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_en1      (wr_en1),
    .wr_en2      (wr_en2),
    .frame_done  (frame_done),
    .frame_error (frame_error)
`ifdef FB_LOADER_DBUF_EN
    ,
    .disp_bank   (disp_bank)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en1;
    logic        en2;
    logic [4:0]  addr;
    logic [23:0] data;
  } exp_t;

  typedef struct {
    logic [7:0]  b;
    logic        wr;
    logic [4:0]  addr;
    logic [23:0] data;
  } vec_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_n = 0, err_n = 0;
  int   done_cyc = 0, err_cyc = 0, last_wr_cyc = 0, last_acc_cyc = 0;
  int   m_idx = 0;
  logic m_bank = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard side: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_en1 || wr_en2) begin
      last_wr_cyc = cyc;
      if (q.size() == 0) begin
        check("unexpected_write", {wr_en2, wr_en1, 3'b0, 5'(wr_addr)}, 32'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("wr_en", {30'b0, wr_en2, wr_en1}, {30'b0, e.en2, e.en1});
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
    if (frame_done) begin done_n++; done_cyc = cyc; end
    if (frame_error) begin err_n++; err_cyc = cyc; end
  end

  function automatic logic [4:0] exp_addr(input int idx);
`ifdef FB_LOADER_DBUF_EN
    return {!m_bank, 4'(idx % NHALF)};
`else
    return {1'b0, 4'(idx % NHALF)};
`endif
  endfunction

  task automatic push_pixel(input logic [23:0] d);
    exp_t e;
    e.en1  = (m_idx < NHALF);
    e.en2  = (m_idx >= NHALF);
    e.addr = exp_addr(m_idx);
    e.data = d;
    q.push_back(e);
    m_idx++;
  endtask

  task automatic send_byte(input logic [7:0] b, output int stall);
    int n;
    n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    stall = n;
    if (!rx_ready) begin
      check("rx_ready_timeout", 32'(rx_ready), 32'h1);
    end else begin
      @(posedge clk);
      #1 last_acc_cyc = cyc;
    end
  endtask

  task automatic idle_bus();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    rx_valid = 1'b0;
    wait_cycles(2);
    reset  = 1'b0;
    m_idx  = 0;
    m_bank = 1'b0;
  endtask

  task automatic send_pixel(input logic [23:0] d);
    int s;
    send_byte(d[7:0], s);
    send_byte(d[15:8], s);
    send_byte(d[23:16], s);
    push_pixel(d);
  endtask

  // SYNC plus a full frame, checking the one-cycle stall after each pixel.
  task automatic send_frame();
    int s;
    logic [23:0] d;
    int d0;
    send_byte(8'hFF, s);
    for (int k = 0; k < 2 * NHALF; k++) begin
      d = 24'($urandom);
      for (int j = 0; j < 3; j++) begin
        send_byte(d[8*j +: 8], s);
        check("stall", 32'(s), (k > 0 && j == 0) ? 32'h1 : 32'h0);
      end
      push_pixel(d);
    end
    d0 = done_n;
    idle_bus();
    wait_cycles(4);
    check("frame_done_count", 32'(done_n - d0), 32'h1);
    check("frame_done_latency", 32'(done_cyc - last_wr_cyc), 32'h1);
    check("queue_drained", 32'(q.size()), 32'h0);
    m_bank = !m_bank;
    m_idx  = 0;
  endtask

  initial begin
    vec_t vec[6];
    int   s, e0;

    vec[0] = '{8'h00, 1'b0, 5'd0, 24'h0};
    vec[1] = '{8'h11, 1'b0, 5'd0, 24'h0};
    vec[2] = '{8'hFF, 1'b0, 5'd0, 24'h0};
    vec[3] = '{8'h10, 1'b0, 5'd0, 24'h0};
    vec[4] = '{8'h20, 1'b0, 5'd0, 24'h0};
    vec[5] = '{8'h30, 1'b1, 5'd0, 24'h302010};

    wait_cycles(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 32'h1);
    check("rst_wr_en", {30'b0, wr_en2, wr_en1}, 32'h0);
    check("rst_pulses", {30'b0, frame_error, frame_done}, 32'h0);
    check("rst_wr_addr", 32'(wr_addr), 32'h0);
    check("rst_wr_data", 32'(wr_data), 32'h0);

    // 1: junk before SYNC is dropped, first pixel goes to addr 0.
    for (int i = 0; i < 6; i++) begin
      send_byte(vec[i].b, s);
      if (vec[i].wr) q.push_back('{1'b1, 1'b0, exp_addr(0), vec[i].data});
    end
    idle_bus();
    wait_cycles(3);
    check("t1_drained", 32'(q.size()), 32'h0);

    // 2: full frame, back to back.
    do_reset();
    send_frame();

    // 3: 0xFF inside a pixel is data, and the following pixel lands at addr 1.
    do_reset();
    send_byte(8'hFF, s);
    send_pixel(24'hFFFFFF);
    send_pixel(24'h302010);
    idle_bus();
    wait_cycles(3);
    check("t3_drained", 32'(q.size()), 32'h0);

    // 4: timeout after 7 bytes aborts; next SYNC restarts at addr 0.
    do_reset();
    e0 = err_n;
    send_byte(8'hFF, s);
    send_pixel(24'h030201);
    send_pixel(24'h060504);
    send_byte(8'h07, s);
    idle_bus();
    for (int i = 0; i < 100 && err_n == e0; i++) @(negedge clk);
    check("t4_error_count", 32'(err_n - e0), 32'h1);
    check("t4_error_window", 32'((err_cyc - last_acc_cyc) >= TMO - 2 && (err_cyc - last_acc_cyc) <= TMO + 2), 32'h1);
    check("t4_drained", 32'(q.size()), 32'h0);
    m_idx = 0;
    send_byte(8'hFF, s);
    send_pixel(24'hABCDEF);
    idle_bus();
    wait_cycles(3);
    check("t4_restart", 32'(q.size()), 32'h0);
    check("t4_no_done", 32'(done_n), 32'h1);

    // 5: reset between the 2nd and 3rd byte kills the pixel.
    do_reset();
    send_byte(8'hFF, s);
    send_byte(8'h01, s);
    send_byte(8'h02, s);
    @(negedge clk);
    rx_data  = 8'h03;
    rx_valid = 1'b1;
    reset    = 1'b1;
    wait_cycles(2);
    reset    = 1'b0;
    rx_valid = 1'b0;
    check("t5_rx_ready", 32'(rx_ready), 32'h1);
    check("t5_wr_en", {30'b0, wr_en2, wr_en1}, 32'h0);
    check("t5_wr_addr", 32'(wr_addr), 32'h0);
    check("t5_wr_data", 32'(wr_data), 32'h0);
    check("t5_pulses", {30'b0, frame_error, frame_done}, 32'h0);
    m_idx = 0;
    send_pixel(24'h302010);
    void'(q.pop_back());
    m_idx = 0;
    send_byte(8'hFF, s);
    send_pixel(24'h665544);
    idle_bus();
    wait_cycles(3);
    check("t5_drained", 32'(q.size()), 32'h0);

`ifdef FB_LOADER_DBUF_EN
    // 6: two frames alternate banks.
    do_reset();
    check("t6_bank0", 32'(disp_bank), 32'h0);
    send_frame();
    check("t6_bank1", 32'(disp_bank), 32'h1);
    send_frame();
    check("t6_bank2", 32'(disp_bank), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
